// File: rtl/joy_scan_ctrl.sv
// joy_scan_ctrl: sequencer for a parallel-in/serial-out joystick shift chain.
// Drives the active-low load and the shift clock, samples the serial data,
// assembles each scan into a parallel frame and publishes it with a one-cycle
// strobe.
// Optional feature macro: JOY_SCAN_DEBOUNCE_EN -- when defined, a frame is
// published only if two consecutive completed scans are identical.
module joy_scan_ctrl #(
   parameter int CLK_DIV  = 16,   // clk cycles per half shift-clock period (>= 2)
   parameter int NBITS    = 24,   // bits per scan frame (1..32)
   parameter int IDLE_GAP = 2     // idle bit-slots between frames (>= 0)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             joy_data,
   output logic             joy_clk,
   output logic             joy_load,
   output logic [NBITS-1:0] frame,
   output logic             frame_valid,
   output logic             busy
);

   // Divider spans one bit slot: 0..2*CLK_DIV-1.
   localparam int DW = $clog2(2 * CLK_DIV);
   // Gap slot counter only needs to reach IDLE_GAP-1.
   localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

   localparam logic [DW-1:0] DIV_LAST       = DW'(2 * CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_LOW_LAST   = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HIGH_FIRST = DW'(CLK_DIV);
   localparam logic [5:0]    BIT_LAST       = 6'(NBITS - 1);
   localparam logic [GW-1:0] GAP_LAST       = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_DONE  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   state_t            state_reg, state_next;
   logic [DW-1:0]     div_reg, div_next;
   logic [5:0]        bit_cnt_reg, bit_cnt_next;
   logic [GW-1:0]     gap_cnt_reg, gap_cnt_next;
   logic [NBITS-1:0]  shift_reg, shift_next;
   logic [NBITS-1:0]  frame_reg;
   logic              frame_valid_reg;
   logic              joy_clk_reg, joy_clk_next;
   logic              joy_load_reg, joy_load_next;
   logic              busy_reg, busy_next;
   logic              slot_end;
   logic              sample;
   logic              scan_match;
   logic              publish;

   assign slot_end = (div_reg == DIV_LAST);
   // Data is captured on the last low-phase cycle, just before joy_clk rises.
   assign sample   = (state_reg == ST_SHIFT) && (div_reg == DIV_LOW_LAST);

   // Next-state, counter and output decode; outputs are computed from the
   // upcoming state so that every port comes straight from a flop.
   always_comb begin
      state_next    = state_reg;
      div_next      = div_reg;
      bit_cnt_next  = bit_cnt_reg;
      gap_cnt_next  = gap_cnt_reg;
      joy_load_next = 1'b1;
      joy_clk_next  = 1'b0;
      busy_next     = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (enable) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            bit_cnt_next = 6'd0;
            if (slot_end) begin
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (slot_end) begin
               bit_cnt_next = bit_cnt_reg + 6'd1;
               if (bit_cnt_reg == BIT_LAST) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            gap_cnt_next = '0;
            if (IDLE_GAP == 0) begin
               state_next = enable ? ST_LOAD : ST_IDLE;
            end else begin
               state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            if (slot_end) begin
               gap_cnt_next = gap_cnt_reg + GW'(1);
               if (gap_cnt_reg == GAP_LAST) begin
                  state_next = enable ? ST_LOAD : ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Divider restarts on every state entry and wraps at each slot end.
      if ((state_next != state_reg) || (state_reg == ST_IDLE) || slot_end) begin
         div_next = '0;
      end else begin
         div_next = div_reg + DW'(1);
      end

      joy_load_next = (state_next != ST_LOAD);
      joy_clk_next  = (state_next == ST_SHIFT) && (div_next >= DIV_HIGH_FIRST);
      busy_next     = (state_next != ST_IDLE);
   end

   // State, counters and registered chain-control outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         div_reg      <= '0;
         bit_cnt_reg  <= 6'd0;
         gap_cnt_reg  <= '0;
         joy_load_reg <= 1'b1;
         joy_clk_reg  <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         div_reg      <= div_next;
         bit_cnt_reg  <= bit_cnt_next;
         gap_cnt_reg  <= gap_cnt_next;
         joy_load_reg <= joy_load_next;
         joy_clk_reg  <= joy_clk_next;
         busy_reg     <= busy_next;
      end
   end

   // Each shift bit owns its slot: serial bit i lands in position NBITS-1-i,
   // so the first bit out of the chain ends up in the MSB.
   generate
      for (genvar gi = 0; gi < NBITS; gi++) begin : g_shift
         assign shift_next[gi] = (sample && (bit_cnt_reg == 6'(NBITS - 1 - gi)))
                                 ? joy_data : shift_reg[gi];
      end
   endgenerate

   // Scan assembly register; reset discards any partial scan.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg <= '1;
      end else begin
         shift_reg <= shift_next;
      end
   end

`ifdef JOY_SCAN_DEBOUNCE_EN
   logic [NBITS-1:0] raw_reg;

   assign scan_match = (shift_reg == raw_reg);

   // Previous completed scan, refreshed at the end of every scan.
   always_ff @(posedge clk) begin
      if (reset) begin
         raw_reg <= '1;
      end else if (state_reg == ST_DONE) begin
         raw_reg <= shift_reg;
      end
   end
`else
   assign scan_match = 1'b1;
`endif

   assign publish = (state_reg == ST_DONE) && scan_match;

   // Published frame holds between updates; strobe marks each update.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_reg       <= '1;
         frame_valid_reg <= 1'b0;
      end else begin
         frame_valid_reg <= publish;
         if (publish) begin
            frame_reg <= shift_reg;
         end
      end
   end

   assign joy_clk     = joy_clk_reg;
   assign joy_load    = joy_load_reg;
   assign frame       = frame_reg;
   assign frame_valid = frame_valid_reg;
   assign busy        = busy_reg;

endmodule
